// File: rtl/execute_md.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and an
// iterative one-bit-per-cycle multiply/divide unit that stalls the front end.

module alu #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_control,
    output logic [XLEN-1:0] y
);
    localparam int SHW = $clog2(XLEN);
    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (alu_control)
            5'd0:    y = a + b;
            5'd1:    y = a - b;
            5'd2:    y = a & b;
            5'd3:    y = a | b;
            5'd4:    y = a ^ b;
            5'd5:    y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'd6:    y = {{(XLEN-1){1'b0}}, a < b};
            5'd7:    y = a << shamt;
            5'd8:    y = a >> shamt;
            5'd9:    y = $signed(a) >>> shamt;
            default: y = '0;
        endcase
    end
endmodule

module execute_md #(
    parameter int XLEN     = 64,
    parameter int MD_CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Valid_E,
    input  logic            Flush_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExt_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [XLEN-1:0] Result_W,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [4:0]      ALUControl_E,
    input  logic            ALUSrc_E,
    input  logic            MDEn_E,
    input  logic [2:0]      MDOp_E,
    input  logic            Branch_E,
    input  logic            Jump_E,
    input  logic            JumpReg_E,
    input  logic [2:0]      BranchOp_E,
    output logic [XLEN-1:0] ALUResult_E,
    output logic [XLEN-1:0] WriteData_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic            PCSrc_E,
    output logic            Stall_E,
    output logic            Done_E
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    md_state_t           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
    logic [2:0]          op_q, op_d;
    logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y, jalr_sum;
    logic            taken, start;

    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a = Result_W;
            2'b10:   src_a = ALUResult_M;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   fwd_b = Result_W;
            2'b10:   fwd_b = ALUResult_M;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b       = ALUSrc_E ? ImmExt_E : fwd_b;
    assign WriteData_E = fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (ALUControl_E),
        .y           (alu_y)
    );

    always_comb begin
        case (BranchOp_E)
            3'b000:  taken = (src_a == fwd_b);
            3'b001:  taken = (src_a != fwd_b);
            3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  taken = (src_a <  fwd_b);
            3'b111:  taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum   = src_a + ImmExt_E;
    assign PCTarget_E = JumpReg_E ? {jalr_sum[XLEN-1:1], 1'b0} : (PC_E + ImmExt_E);
    assign PCSrc_E    = Valid_E & ~Flush_E & (Jump_E | (Branch_E & taken));

    // Operand sign resolution at start: the iteration only ever sees magnitudes.
    logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        a_signed    = (MDOp_E == 3'd1) || (MDOp_E == 3'd2) || (MDOp_E == 3'd4) || (MDOp_E == 3'd6);
        b_signed    = (MDOp_E == 3'd1) || (MDOp_E == 3'd4) || (MDOp_E == 3'd6);
        a_neg       = a_signed & src_a[XLEN-1];
        b_neg       = b_signed & fwd_b[XLEN-1];
        a_mag       = a_neg ? -src_a : src_a;
        b_mag       = b_neg ? -fwd_b : fwd_b;
        div_zero    = MDOp_E[2] && (fwd_b == '0);
        div_ovf     = MDOp_E[2] && !MDOp_E[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (fwd_b == '1);
        special_res = '0;
        if (div_zero)
            special_res = MDOp_E[1] ? src_a : '1;
        else if (div_ovf)
            special_res = MDOp_E[1] ? '0 : src_a;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, quo, rem, final_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {step_hi, step_lo};
        prod_s = neg_quo_q ? -prod : prod;
        quo    = neg_quo_q ? -step_lo : step_lo;
        rem    = neg_rem_q ? -step_hi : step_hi;
        case (op_q)
            3'd0:       final_res = prod_s[XLEN-1:0];
            3'd4, 3'd5: final_res = quo;
            3'd6, 3'd7: final_res = rem;
            default:    final_res = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    assign start = (state_q == S_IDLE) & Valid_E & MDEn_E & ~Flush_E;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = MDOp_E;
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        state_d = S_DONE;
                    end else begin
                        hi_d      = '0;
                        lo_d      = a_mag;
                        b_d       = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = MD_CNT_W'(XLEN);
                        state_d   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == MD_CNT_W'(1)) begin
                    res_d   = final_res;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Flush_E)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
        end
    end

    assign Stall_E     = ~rst & ~Flush_E & (start | (state_q == S_BUSY));
    assign Done_E      = ~rst & ~Flush_E & (state_q == S_DONE);
    assign ALUResult_E = Done_E ? res_q : alu_y;
endmodule

// File: tb/tb_execute_md.sv
// Directed plus randomized bench for execute_md with a 128-bit arithmetic
// reference model for the M-extension ops and branch/target rules.

module tb_execute_md;
    localparam int XLEN = 64;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic            clk, rst;
    logic            Valid_E, Flush_E;
    logic [XLEN-1:0] RD1_E, RD2_E, ImmExt_E, PC_E, ALUResult_M, Result_W;
    logic [1:0]      ForwardA_E, ForwardB_E;
    logic [4:0]      ALUControl_E;
    logic            ALUSrc_E, MDEn_E;
    logic [2:0]      MDOp_E;
    logic            Branch_E, Jump_E, JumpReg_E;
    logic [2:0]      BranchOp_E;
    logic [XLEN-1:0] ALUResult_E, WriteData_E, PCTarget_E;
    logic            PCSrc_E, Stall_E, Done_E;

    int checks   = 0;
    int failures = 0;

    execute_md #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .Valid_E(Valid_E), .Flush_E(Flush_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E), .PC_E(PC_E),
        .ALUResult_M(ALUResult_M), .Result_W(Result_W),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ALUControl_E(ALUControl_E), .ALUSrc_E(ALUSrc_E),
        .MDEn_E(MDEn_E), .MDOp_E(MDOp_E),
        .Branch_E(Branch_E), .Jump_E(Jump_E), .JumpReg_E(JumpReg_E), .BranchOp_E(BranchOp_E),
        .ALUResult_E(ALUResult_E), .WriteData_E(WriteData_E), .PCTarget_E(PCTarget_E),
        .PCSrc_E(PCSrc_E), .Stall_E(Stall_E), .Done_E(Done_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: RISC-V M semantics on 128-bit signed arithmetic.
    function automatic logic [63:0] md_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[63:0];   end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            3'd4: begin
                if (b == 64'd0) return '1;
                if (a == MIN64 && b == '1) return a;
                p = sa / sb; return p[63:0];
            end
            3'd5: return (b == 64'd0) ? '1 : a / b;
            3'd6: begin
                if (b == 64'd0) return a;
                if (a == MIN64 && b == '1) return 64'd0;
                p = sa % sb; return p[63:0];
            end
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic br_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic quiet();
        Valid_E = 0; Flush_E = 0; MDEn_E = 0; MDOp_E = 0;
        Branch_E = 0; Jump_E = 0; JumpReg_E = 0; BranchOp_E = 0;
        ForwardA_E = 0; ForwardB_E = 0; ALUSrc_E = 0; ALUControl_E = 0;
    endtask

    task automatic scramble();
        RD1_E = rnd64(); RD2_E = rnd64(); ALUResult_M = rnd64(); Result_W = rnd64();
    endtask

    // fa/fb: forwarding select to route a/b through; 4 picks one at random.
    task automatic run_md(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int fa_in, input int fb_in, input string tag);
        logic [63:0] exp_res;
        int exp_stall, stalls, fa, fb;
        logic special;
        exp_res   = md_model(op, a, b);
        special   = op[2] && (b == 64'd0 || (!op[0] && a == MIN64 && b == '1));
        exp_stall = special ? 1 : XLEN + 1;
        fa = (fa_in == 4) ? int'($urandom_range(0, 3)) : fa_in;
        fb = (fb_in == 4) ? int'($urandom_range(0, 3)) : fb_in;
        if (fb == fa && (fa == 1 || fa == 2)) fb = 0;
        @(negedge clk);
        scramble();
        case (fa)
            1: Result_W = a;
            2: ALUResult_M = a;
            default: RD1_E = a;
        endcase
        case (fb)
            1: Result_W = b;
            2: ALUResult_M = b;
            default: RD2_E = b;
        endcase
        ForwardA_E = 2'(fa); ForwardB_E = 2'(fb);
        Valid_E = 1; MDEn_E = 1; MDOp_E = op;
        #1;
        stalls = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (Done_E || !Stall_E) break;
            stalls++;
            @(negedge clk);
            scramble();
            #1;
        end
        chk($sformatf("%s_done", tag), 64'(Done_E), 64'd1);
        chk($sformatf("%s_stall_cycles", tag), 64'(stalls), 64'(exp_stall));
        chk($sformatf("%s_result", tag), ALUResult_E, exp_res);
        chk($sformatf("%s_no_stall_in_done", tag), 64'(Stall_E), 64'd0);
        $display("md %s op=%0d a=%h b=%h res=%h stalls=%0d", tag, op, a, b, ALUResult_E, stalls);
        Valid_E = 0; MDEn_E = 0;
        @(negedge clk);
        #1;
        chk($sformatf("%s_back_idle", tag), 64'(Done_E), 64'd0);
    endtask

    task automatic run_br(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input string tag);
        @(negedge clk);
        quiet();
        RD1_E = a; RD2_E = b; PC_E = rnd64(); ImmExt_E = rnd64();
        Valid_E = 1; Branch_E = 1; BranchOp_E = op;
        #1;
        chk($sformatf("%s_pcsrc", tag), 64'(PCSrc_E), 64'(br_model(op, a, b)));
        chk($sformatf("%s_target", tag), PCTarget_E, PC_E + ImmExt_E);
        $display("br %s op=%0d a=%h b=%h pcsrc=%0b", tag, op, a, b, PCSrc_E);
    endtask

    initial begin
        logic [63:0] a, b, exp_sum;
        int seen_done;
        quiet();
        scramble();
        PC_E = 0; ImmExt_E = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        Valid_E = 1; MDEn_E = 1; ALUControl_E = 5'd0;
        #1;
        chk("reset_stall", 64'(Stall_E), 64'd0);
        chk("reset_done", 64'(Done_E), 64'd0);
        chk("reset_alu_add", ALUResult_E, RD1_E + RD2_E);
        quiet();
        @(negedge clk);
        rst = 0;

        // Plain ALU ops never stall; forwarding and immediate selection.
        @(negedge clk);
        Valid_E = 1; ALUControl_E = 5'd0; ALUSrc_E = 1; ImmExt_E = 64'd40; RD1_E = 64'd2;
        #1;
        chk("alu_add_imm", ALUResult_E, 64'd42);
        chk("alu_no_stall", 64'(Stall_E), 64'd0);
        @(negedge clk);
        ALUControl_E = 5'd1; ALUSrc_E = 0; ForwardA_E = 2'b01; ForwardB_E = 2'b10;
        Result_W = 64'd1000; ALUResult_M = 64'd1;
        #1;
        chk("alu_sub_fwd", ALUResult_E, 64'd999);
        chk("writedata_fwd", WriteData_E, 64'd1);
        $display("alu checks done");

        // Directed M-unit cases.
        run_md(3'd0, 64'd7, -64'sd3, 0, 0, "mul_7_m3");
        run_md(3'd4, 64'd100, 64'd0, 0, 0, "div_by_zero");
        run_md(3'd6, 64'd100, 64'd0, 0, 0, "rem_by_zero");
        run_md(3'd4, MIN64, '1, 0, 0, "div_ovf");
        run_md(3'd6, MIN64, '1, 0, 0, "rem_ovf");
        run_md(3'd3, '1, 64'd2, 2, 0, "mulhu_fwd_m");
        run_md(3'd1, MIN64, MIN64, 1, 2, "mulh_min");
        run_md(3'd2, -64'sd1, '1, 0, 1, "mulhsu_m1");
        run_md(3'd4, -64'sd7, 64'd2, 0, 0, "div_neg");
        run_md(3'd6, -64'sd7, 64'd2, 0, 0, "rem_neg");

        // Flush during BUSY aborts without a Done pulse.
        @(negedge clk);
        quiet();
        RD1_E = 64'd1000; RD2_E = 64'd7;
        Valid_E = 1; MDEn_E = 1; MDOp_E = 3'd5;
        #1;
        chk("flush_start_stall", 64'(Stall_E), 64'd1);
        for (int i = 1; i <= 9; i++) @(negedge clk);
        #1;
        chk("flush_busy_stall", 64'(Stall_E), 64'd1);
        @(negedge clk);
        Flush_E = 1;
        #1;
        chk("flush_stall_low", 64'(Stall_E), 64'd0);
        chk("flush_done_low", 64'(Done_E), 64'd0);
        @(negedge clk);
        Flush_E = 0; Valid_E = 0; MDEn_E = 0;
        seen_done = 0;
        for (int i = 0; i < 70; i++) begin
            #1;
            if (Done_E || Stall_E) seen_done++;
            @(negedge clk);
        end
        chk("flush_no_done_after", 64'(seen_done), 64'd0);
        $display("flush test done");
        run_md(3'd5, 64'd9, 64'd3, 0, 0, "divu_after_flush");

        // Reset mid-operation behaves like a flush.
        @(negedge clk);
        quiet();
        RD1_E = 64'd5; RD2_E = 64'd6;
        Valid_E = 1; MDEn_E = 1; MDOp_E = 3'd0;
        repeat (5) @(negedge clk);
        rst = 1;
        #1;
        chk("rst_mid_stall", 64'(Stall_E), 64'd0);
        @(negedge clk);
        rst = 0; Valid_E = 0; MDEn_E = 0;
        seen_done = 0;
        for (int i = 0; i < 70; i++) begin
            #1;
            if (Done_E || Stall_E) seen_done++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", 64'(seen_done), 64'd0);
        $display("reset-abort test done");

        // Randomized M ops with random forwarding and corner operands.
        for (int n = 0; n < 30; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = MIN64;
                1: a = 64'($urandom_range(0, 100000));
                2: a = -64'($urandom_range(1, 100000));
                default: a = rnd64();
            endcase
            case ($urandom_range(0, 4))
                0: b = 64'd0;
                1: b = '1;
                2: b = 64'($urandom_range(1, 1000));
                3: b = -64'($urandom_range(1, 1000));
                default: b = rnd64();
            endcase
            run_md(op, a, b, 4, 4, $sformatf("rand%0d", n));
        end

        // Branches: directed signed/unsigned, then random over all funct3 codes.
        run_br(3'b100, '1, 64'd1, "blt_m1_1");
        run_br(3'b110, '1, 64'd1, "bltu_m1_1");
        run_br(3'b010, 64'd3, 64'd3, "bundef");
        for (int n = 0; n < 24; n++) begin
            a = rnd64();
            b = ($urandom_range(0, 2) == 0) ? a : rnd64();
            if ($urandom_range(0, 3) == 0) a = {~b[63], a[62:0]};
            run_br(3'($urandom_range(0, 7)), a, b, $sformatf("br_rand%0d", n));
        end

        // Flushed or invalid branch never redirects.
        @(negedge clk);
        quiet();
        RD1_E = 64'd4; RD2_E = 64'd4; Valid_E = 1; Branch_E = 1; BranchOp_E = 3'b000; Flush_E = 1;
        #1;
        chk("beq_flushed", 64'(PCSrc_E), 64'd0);
        @(negedge clk);
        Flush_E = 0; Valid_E = 0;
        #1;
        chk("beq_invalid", 64'(PCSrc_E), 64'd0);

        // JALR masks bit 0 of the target; JAL uses PC + imm.
        @(negedge clk);
        quiet();
        RD1_E = 64'h1001; ImmExt_E = 64'd4; PC_E = 64'h8000;
        Valid_E = 1; Jump_E = 1; JumpReg_E = 1;
        #1;
        chk("jalr_target", PCTarget_E, 64'h1004);
        chk("jalr_pcsrc", 64'(PCSrc_E), 64'd1);
        $display("jalr target=%h pcsrc=%0b", PCTarget_E, PCSrc_E);
        @(negedge clk);
        JumpReg_E = 0; RD1_E = 64'h3; ForwardA_E = 2'b01; Result_W = 64'h7777; ImmExt_E = 64'h11;
        exp_sum = 64'h8011;
        #1;
        chk("jal_target", PCTarget_E, exp_sum);
        @(negedge clk);
        JumpReg_E = 1;
        #1;
        chk("jalr_fwd_target", PCTarget_E, 64'h7788);
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
